// File: rtl/commit_sync_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commit_sync_buffer_pkg
// Description : Shared types for the commit-synchronisation buffer: default
//               record widths (matching the ISA model parameters), the
//               retired-instruction record and the step/check FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package commit_sync_buffer_pkg;

  // Default field widths, kept in line with the ISA reference model header
  localparam int unsigned c_PC_W   = 4;
  localparam int unsigned c_RF_AW  = 2;
  localparam int unsigned c_DATA_W = 4;

  // One retired-instruction record as seen on the verification commit port
  typedef struct packed {
    logic [c_PC_W-1:0]   pc;
    logic                we;
    logic [c_RF_AW-1:0]  rd;
    logic [c_DATA_W-1:0] data;
  } commit_rec_t;

  // Step/check sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } sync_state_e;

endpackage : commit_sync_buffer_pkg
`default_nettype wire

// File: rtl/commit_sync_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : commit_fifo
// Description : Synchronous FIFO holding buffered commit records. Exposes the
//               head entry combinationally, plus occupancy and full flag.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_CW = c_AW + 1;

  logic [W-1:0]      r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;

  // Storage: contents need no reset, occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == c_CW'(DEPTH));

endmodule : commit_fifo
`default_nettype wire

// File: rtl/commit_sync_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_sync_buffer
// Description : Buffers OOO-core retirement records and steps the ISA model
//               once per record through an explicit step handshake, comparing
//               each ISA retirement with the buffered OOO record. Reports a
//               sticky mismatch (with the first failing pc) and a sticky
//               liveness failure when commits stop arriving.
//               Optional feature macro: COMMIT_SYNC_DATA_CHECK_EN - when
//               defined, we/rd/data are stored and compared as well as pc.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_sync_buffer
  import commit_sync_buffer_pkg::*;
#(
  parameter int unsigned PC_W    = c_PC_W,
  parameter int unsigned RF_AW   = c_RF_AW,
  parameter int unsigned DATA_W  = c_DATA_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_valid,
  input  logic [PC_W-1:0]        commit_pc,
  input  logic                   commit_we,
  input  logic [RF_AW-1:0]       commit_rd,
  input  logic [DATA_W-1:0]      commit_data,
  output logic                   commit_ready,
  output logic                   isa_step,
  input  logic [PC_W-1:0]        isa_pc_last,
  input  logic                   isa_we,
  input  logic [RF_AW-1:0]       isa_rd,
  input  logic [DATA_W-1:0]      isa_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mismatch,
  output logic [PC_W-1:0]        mismatch_pc,
  output logic                   live_fail,
  output logic [15:0]            checked_cnt
);

  localparam int unsigned c_CW = $clog2(DEPTH) + 1;
  localparam int unsigned c_TW = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(TIMEOUT);
`ifdef COMMIT_SYNC_DATA_CHECK_EN
  localparam int unsigned c_REC_W = PC_W + 1 + RF_AW + DATA_W;
`else
  localparam int unsigned c_REC_W = PC_W;
`endif

  sync_state_e       r_state;
  sync_state_e       w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_fail;
  logic              w_full;
  logic              w_match;
  logic [c_REC_W-1:0] w_wdata;
  logic [c_REC_W-1:0] w_head;
  logic [PC_W-1:0]   w_head_pc;
  logic [c_CW-1:0]   w_cnt_after;
  logic [15:0]       r_checked;
  logic              r_mismatch;
  logic [PC_W-1:0]   r_mismatch_pc;
  logic [c_TW-1:0]   r_idle;
  logic [c_TW-1:0]   w_idle_nxt;
  logic              r_live_fail;

  // Ready is forced high during reset because occupancy is being cleared
  assign commit_ready = rst || !w_full;
  assign w_push       = commit_valid && commit_ready && !rst;

`ifdef COMMIT_SYNC_DATA_CHECK_EN
  logic              w_head_we;
  logic [RF_AW-1:0]  w_head_rd;
  logic [DATA_W-1:0] w_head_data;

  assign w_wdata     = {commit_pc, commit_we, commit_rd, commit_data};
  assign w_head_pc   = w_head[c_REC_W-1 -: PC_W];
  assign w_head_we   = w_head[RF_AW + DATA_W];
  assign w_head_rd   = w_head[DATA_W +: RF_AW];
  assign w_head_data = w_head[DATA_W-1:0];
  // rd/data only matter when the instruction actually wrote the register file
  assign w_match = (w_head_pc == isa_pc_last) && (w_head_we == isa_we) &&
                   (!w_head_we || ((w_head_rd == isa_rd) && (w_head_data == isa_data)));
`else
  logic w_unused_data_fields;

  assign w_wdata   = commit_pc;
  assign w_head_pc = w_head;
  assign w_match   = (w_head_pc == isa_pc_last);
  // Write-info ports exist for interface compatibility only in this build
  assign w_unused_data_fields = ^{commit_we, commit_rd, commit_data,
                                  isa_we, isa_rd, isa_data};
`endif

  commit_fifo #(
    .W     (c_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (count),
    .o_full  (w_full)
  );

  // Occupancy once the current head has been popped; only used in CHECK,
  // where the FIFO is guaranteed to hold at least the record being checked
  assign w_cnt_after = count - c_CW'(1) + c_CW'(w_push);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: one STEP then one CHECK per buffered record
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if ((count != '0) || w_push) w_state_nxt = ST_STEP;
      ST_STEP:  w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!w_match)                w_state_nxt = ST_HALT;
        else if (w_cnt_after != '0)  w_state_nxt = ST_STEP;
        else                         w_state_nxt = ST_IDLE;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: step strobe, pop on a good compare, fail on a bad compare
  always_comb begin
    isa_step = (r_state == ST_STEP);
    w_pop    = (r_state == ST_CHECK) && w_match;
    w_fail   = (r_state == ST_CHECK) && !w_match;
  end

  // Check results: pass counter and sticky first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checked     <= '0;
      r_mismatch    <= 1'b0;
      r_mismatch_pc <= '0;
    end else begin
      if (w_pop) r_checked <= r_checked + 16'd1;
      if (w_fail) begin
        r_mismatch    <= 1'b1;
        r_mismatch_pc <= w_head_pc;
      end
    end
  end

  // Idle counter: cleared by an accepted commit, otherwise counts up and saturates
  always_comb begin
    if (w_push)                  w_idle_nxt = '0;
    else if (r_idle == c_TIMEOUT) w_idle_nxt = r_idle;
    else                         w_idle_nxt = r_idle + c_TW'(1);
  end

  // Liveness flag rises on the edge the idle counter reaches the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle      <= '0;
      r_live_fail <= 1'b0;
    end else begin
      r_idle <= w_idle_nxt;
      if (w_idle_nxt == c_TIMEOUT) r_live_fail <= 1'b1;
    end
  end

  assign checked_cnt = r_checked;
  assign mismatch    = r_mismatch;
  assign mismatch_pc = r_mismatch_pc;
  assign live_fail   = r_live_fail;

endmodule : commit_sync_buffer
`default_nettype wire

// File: tb/tb_commit_sync_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_sync_buffer
// Description : Self-checking bench for commit_sync_buffer. Contains a small
//               ISA model that retires one programmed record per isa_step and
//               a record-level scoreboard (queues of OOO/ISA records).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_sync_buffer;
  import commit_sync_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [3:0]  commit_pc;
  logic        commit_we;
  logic [1:0]  commit_rd;
  logic [3:0]  commit_data;
  logic        commit_ready;
  logic        isa_step;
  logic [3:0]  isa_pc_last;
  logic        isa_we;
  logic [1:0]  isa_rd;
  logic [3:0]  isa_data;
  logic [2:0]  count;
  logic        mismatch;
  logic [3:0]  mismatch_pc;
  logic        live_fail;
  logic [15:0] checked_cnt;

  always #5 clk = ~clk;

  commit_sync_buffer #(
    .PC_W(4), .RF_AW(2), .DATA_W(4), .DEPTH(DEPTH), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_we(commit_we),
    .commit_rd(commit_rd), .commit_data(commit_data), .commit_ready(commit_ready),
    .isa_step(isa_step), .isa_pc_last(isa_pc_last), .isa_we(isa_we),
    .isa_rd(isa_rd), .isa_data(isa_data), .count(count), .mismatch(mismatch),
    .mismatch_pc(mismatch_pc), .live_fail(live_fail), .checked_cnt(checked_cnt)
  );

  // ISA reference model: retires the next programmed instruction per step
  commit_rec_t prog [64];
  int          isa_idx;
  always @(posedge clk) begin
    if (rst) begin
      isa_idx     <= 0;
      isa_pc_last <= '0;
      isa_we      <= 1'b0;
      isa_rd      <= '0;
      isa_data    <= '0;
    end else if (isa_step) begin
      isa_pc_last <= prog[isa_idx].pc;
      isa_we      <= prog[isa_idx].we;
      isa_rd      <= prog[isa_idx].rd;
      isa_data    <= prog[isa_idx].data;
      isa_idx     <= isa_idx + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int steps = 0;
  logic prev_step = 1'b0;
  int step_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (isa_step === 1'b1) begin
      steps++;
      step_cyc.push_back(cyc);
      chk("step_not_back_to_back", {31'd0, prev_step}, 32'd0);
    end
    prev_step = isa_step;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    commit_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    steps = 0;
    prev_step = 1'b0;
    step_cyc.delete();
  endtask

  // Hold a record on the commit port until accepted (bounded)
  task automatic send(input commit_rec_t r);
    bit ok;
    ok = 1'b0;
    commit_valid = 1'b1;
    commit_pc    = r.pc;
    commit_we    = r.we;
    commit_rd    = r.rd;
    commit_data  = r.data;
    for (int g = 0; g < 50 && !ok; g++) begin
      ok = commit_ready;
      tick();
    end
    commit_valid = 1'b0;
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  function automatic commit_rec_t mkrec(input logic [3:0] pc, input logic we,
                                        input logic [1:0] rd, input logic [3:0] data);
    commit_rec_t r;
    r.pc = pc; r.we = we; r.rd = rd; r.data = data;
    return r;
  endfunction

  commit_rec_t recs [64];
  int exp_mm;
  int exp_ok;

  initial begin
    rst = 1'b1;
    commit_valid = 1'b0;
    commit_pc = '0; commit_we = 1'b0; commit_rd = '0; commit_data = '0;
    for (int i = 0; i < 64; i++) prog[i] = mkrec(4'd0, 1'b0, 2'd0, 4'd0);
    #1;
    chk("ready_before_first_edge", {31'd0, commit_ready}, 32'd1);

    // ---------------- reset values ----------------
    tick();
    chk("rst_ready_during", {31'd0, commit_ready}, 32'd1);
    do_reset();
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_step", {31'd0, isa_step}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_mismatch_pc", {28'd0, mismatch_pc}, 32'd0);
    chk("rst_live", {31'd0, live_fail}, 32'd0);
    chk("rst_checked", {16'd0, checked_cnt}, 32'd0);

    // ---------------- liveness: 10 idle cycles ----------------
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9)  chk("live_at_9", {31'd0, live_fail}, 32'd0);
      if (k == 10) chk("live_at_10", {31'd0, live_fail}, 32'd1);
    end
    prog[0] = mkrec(4'd9, 1'b0, 2'd0, 4'd0);
    send(mkrec(4'd9, 1'b0, 2'd0, 4'd0));
    repeat (5) tick();
    chk("live_sticky", {31'd0, live_fail}, 32'd1);
    chk("live_checked", {16'd0, checked_cnt}, 32'd1);

    // ---------------- single commit pc=3 ----------------
    do_reset();
    prog[0] = mkrec(4'd3, 1'b1, 2'd1, 4'd6);
    send(mkrec(4'd3, 1'b1, 2'd1, 4'd6));
    chk("single_count_after_push", {29'd0, count}, 32'd1);
    chk("single_step_high", {31'd0, isa_step}, 32'd1);
    tick();
    chk("single_step_low", {31'd0, isa_step}, 32'd0);
    tick();
    chk("single_checked", {16'd0, checked_cnt}, 32'd1);
    chk("single_count_empty", {29'd0, count}, 32'd0);
    repeat (4) tick();
    chk("single_steps", steps, 32'd1);
    chk("single_mismatch", {31'd0, mismatch}, 32'd0);

    // ---------------- 6 back-to-back commits ----------------
    do_reset();
    begin
      bit saw_full;
      saw_full = 1'b0;
      for (int i = 0; i < 6; i++) prog[i] = mkrec(4'(i), 1'b0, 2'd0, 4'd0);
      for (int i = 0; i < 6; i++) begin
        send(mkrec(4'(i), 1'b0, 2'd0, 4'd0));
        if (count == 3'd4 && commit_ready == 1'b0) saw_full = 1'b1;
      end
      for (int g = 0; g < 40 && checked_cnt != 16'd6; g++) tick();
      chk("b2b_full_seen", {31'd0, saw_full}, 32'd1);
      chk("b2b_checked", {16'd0, checked_cnt}, 32'd6);
      chk("b2b_count", {29'd0, count}, 32'd0);
      chk("b2b_steps", steps, 32'd6);
      for (int i = 1; i < step_cyc.size(); i++)
        chk("b2b_step_gap", step_cyc[i] - step_cyc[i-1], 32'd2);
    end

    // ---------------- mismatch on third record ----------------
    do_reset();
    prog[0] = mkrec(4'd5, 1'b0, 2'd0, 4'd0);
    prog[1] = mkrec(4'd6, 1'b0, 2'd0, 4'd0);
    prog[2] = mkrec(4'd6, 1'b0, 2'd0, 4'd0);
    send(mkrec(4'd5, 1'b0, 2'd0, 4'd0));
    send(mkrec(4'd6, 1'b0, 2'd0, 4'd0));
    send(mkrec(4'd7, 1'b0, 2'd0, 4'd0));
    repeat (12) tick();
    chk("mm_flag", {31'd0, mismatch}, 32'd1);
    chk("mm_pc", {28'd0, mismatch_pc}, 32'd7);
    chk("mm_checked", {16'd0, checked_cnt}, 32'd2);
    chk("mm_steps", steps, 32'd3);
    chk("mm_count_left", {29'd0, count}, 32'd1);
    send(mkrec(4'd8, 1'b0, 2'd0, 4'd0));
    repeat (4) tick();
    chk("halt_push_count", {29'd0, count}, 32'd2);
    chk("halt_no_step", steps, 32'd3);

    // ---------------- data-only difference ----------------
    do_reset();
    prog[0] = mkrec(4'd2, 1'b1, 2'd1, 4'd4);
    send(mkrec(4'd2, 1'b1, 2'd1, 4'd5));
    repeat (6) tick();
`ifdef COMMIT_SYNC_DATA_CHECK_EN
    exp_mm = 1; exp_ok = 0;
`else
    exp_mm = 0; exp_ok = 1;
`endif
    chk("data_mismatch", {31'd0, mismatch}, exp_mm);
    chk("data_checked", {16'd0, checked_cnt}, exp_ok);

    // ---------------- reset in STEP with count=2 ----------------
    do_reset();
    for (int i = 0; i < 3; i++) prog[i] = mkrec(4'(i + 10), 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 3; i++) send(mkrec(4'(i + 10), 1'b0, 2'd0, 4'd0));
    chk("pre_rst_step", {31'd0, isa_step}, 32'd1);
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    chk("pre_rst_checked", {16'd0, checked_cnt}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_step", {31'd0, isa_step}, 32'd0);
    chk("mid_rst_checked", {16'd0, checked_cnt}, 32'd0);
    chk("mid_rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("mid_rst_live", {31'd0, live_fail}, 32'd0);
    chk("mid_rst_ready", {31'd0, commit_ready}, 32'd1);
    rst = 1'b0;

    // ---------------- random, all matching ----------------
    do_reset();
    begin
      int idx;
      bit acc;
      for (int i = 0; i < 40; i++) begin
        recs[i] = mkrec(4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        prog[i] = recs[i];
      end
      idx = 0;
      for (int c = 0; c < 400 && idx < 40; c++) begin
        commit_valid = ($urandom_range(0, 3) != 0);
        commit_pc = recs[idx].pc; commit_we = recs[idx].we;
        commit_rd = recs[idx].rd; commit_data = recs[idx].data;
        acc = commit_valid && commit_ready;
        tick();
        if (acc) idx++;
      end
      commit_valid = 1'b0;
      chk("randA_pushed", idx, 32'd40);
      for (int g = 0; g < 200 && checked_cnt != 16'd40; g++) tick();
      chk("randA_checked", {16'd0, checked_cnt}, 32'd40);
      chk("randA_count", {29'd0, count}, 32'd0);
      chk("randA_mismatch", {31'd0, mismatch}, 32'd0);
      chk("randA_steps", steps, 32'd40);
    end

    // ---------------- random, one corrupted ISA retirement ----------------
    do_reset();
    begin
      int idx;
      int j;
      bit acc;
      j = $urandom_range(0, 15);
      for (int i = 0; i < 40; i++) begin
        recs[i] = mkrec(4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        prog[i] = recs[i];
      end
      prog[j].pc = recs[j].pc ^ 4'h1;
      idx = 0;
      for (int c = 0; c < 150 && idx < 40; c++) begin
        commit_valid = ($urandom_range(0, 3) != 0);
        commit_pc = recs[idx].pc; commit_we = recs[idx].we;
        commit_rd = recs[idx].rd; commit_data = recs[idx].data;
        acc = commit_valid && commit_ready;
        tick();
        if (acc) idx++;
      end
      commit_valid = 1'b0;
      repeat (10) tick();
      chk("randB_mismatch", {31'd0, mismatch}, 32'd1);
      chk("randB_pc", {28'd0, mismatch_pc}, {28'd0, recs[j].pc});
      chk("randB_checked", {16'd0, checked_cnt}, j);
      chk("randB_steps", steps, j + 1);
      chk("randB_count", {29'd0, count}, idx - j);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_commit_sync_buffer
`default_nettype wire

// File: doc/commit_sync_buffer.md
# commit_sync_buffer

Commit-synchronisation buffer for the lock-step equivalence harness. Accepts one retired-instruction record per cycle from the OOO core's verification commit port and buffers it in a FIFO. Steps the ISA reference model exactly once per buffered record and compares the ISA retirement against the OOO record. Replaces free-running ISA clock gating with an explicit step handshake, and reports sticky mismatch and liveness failures to the top-level properties.

## Interface
Parameters:
- PC_W, 4, width of pc fields
- RF_AW, 2, register-file index width
- DATA_W, 4, register data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 10, max cycles without an accepted commit before live_fail

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid  in  1  OOO retired one instruction this cycle
- commit_pc  in  PC_W  pc of retired instruction
- commit_we  in  1  retired instruction writes rf
- commit_rd  in  RF_AW  destination index
- commit_data  in  DATA_W  written value
- commit_ready  out  1  FIFO can accept; = (count != DEPTH)
- isa_step  out  1  ISA retires one instruction at this rising edge
- isa_pc_last  in  PC_W  ISA pc of last retired instruction
- isa_we, isa_rd, isa_data  in  1/RF_AW/DATA_W  ISA last write info
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- mismatch  out  1  sticky compare failure
- mismatch_pc  out  PC_W  OOO pc of first failing record
- live_fail  out  1  sticky liveness failure
- checked_cnt  out  16  records compared OK, wraps

## Operation
- Push: at an edge with commit_valid && commit_ready && !rst, write record at wr_ptr; wr_ptr+1 mod DEPTH.
- commit_valid while !commit_ready: record dropped. The harness must stall the OOO when commit_ready=0.
- FSM states IDLE, STEP, CHECK, HALT. Moore output: isa_step = (state==STEP).
  - IDLE→STEP when count≠0.
  - STEP→CHECK unconditionally. The ISA retires at the edge closing STEP, so its outputs are valid throughout CHECK.
  - CHECK: compare head against ISA, then pop (rd_ptr+1). On match: checked_cnt+1; go to STEP if count after pop ≠0, else IDLE.
  - CHECK on mismatch: set mismatch, latch mismatch_pc = head pc, go to HALT. No pop on mismatch.
  - HALT: absorbing until rst. No further steps; pushes continue while ready.
- Match: head.pc == isa_pc_last, plus the data check when configured.
- Simultaneous push and pop in CHECK: count unchanged. A push into a full FIFO is impossible because ready is computed from pre-pop count.
- Liveness: idle_cnt clears on accepted push, else increments, saturating at TIMEOUT. live_fail sets when idle_cnt==TIMEOUT. It is independent of FSM state.

## Timing
- Reset values: state=IDLE, pointers 0, count=0, isa_step=0, mismatch=0, mismatch_pc=0, live_fail=0, checked_cnt=0, idle_cnt=0. commit_ready=1 during and after reset; pushes are ignored while rst=1.
- Push at edge t: count updates at t. isa_step is high for the cycle t→t+1; compare happens in cycle t+1→t+2.
- Steady-state throughput is one check per 2 cycles. A sustained 1/cycle OOO commit stream fills the FIFO and deasserts commit_ready.
- rst mid-operation: all state returns to reset values at that edge, FIFO contents discarded. An in-flight STEP is abandoned; the ISA model is reset by the same rst.

## Configuration
- COMMIT_SYNC_DATA_CHECK_EN defined: match also requires head.we==isa_we and, when we=1, head.rd==isa_rd && head.data==isa_data.
- Undefined: the we/rd/data FIFO fields are not stored and only pc is compared. commit_we/rd/data and isa_we/rd/data remain as ports and are ignored.

## Structure
- Shared package holds: commit record typedef {pc, we, rd, data}, FSM state enum, and PC_W/RF_AW/DATA_W defaults. These widths match the ISA param header.
- One sub-module, commit_fifo: synchronous FIFO with push, pop, count and head outputs. FSM, comparator and liveness logic stay in the top.

## Test plan
- Single commit pc=3 after reset, ISA returns pc_last=3 → isa_step high exactly 1 cycle, checked_cnt=1, count back to 0, mismatch=0.
- 6 back-to-back commits pc=0..5, DEPTH=4, OOO stalled on !ready → commit_ready low when count=4, all 6 checked, isa_step pulses 6 times each 2 cycles apart.
- Third record pc=7 while ISA returns 6 → mismatch=1, mismatch_pc=7, FSM in HALT, no further isa_step, checked_cnt=2.
- No commits for 10 cycles after reset → live_fail=1 at cycle 10, and it stays 1 after later commits.
- With COMMIT_SYNC_DATA_CHECK_EN, equal pc but data 5 vs ISA 4 → mismatch=1. Without the macro, the same stimulus gives mismatch=0.
- rst asserted in STEP with count=2 → next cycle count=0, isa_step=0, flags 0, commit_ready=1.
